gpio_pin_ctrl: RTL and testbench

Pin-side GPIO core that sits directly downstream of the gpioIP AXI4-Lite slave register interface. It holds output data, direction and interrupt-enable state, and drives the GPIO pads through a tristate triple. It synchronises and debounces pad inputs and raises a level interrupt on debounced input edges. Software reaches it through a simple word-indexed register port decoded from the AXI4-Lite slave's write and read channels.

---
 rtl/gpio_pin_ctrl.sv | 155 +++++++++++++++
 tb/tb_gpio_pin_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pin_ctrl.sv
// Pin-side GPIO core: output/direction/interrupt-enable registers, tristate pad drive,
// synchronised and debounced inputs, and a level interrupt on accepted input edges.
module gpio_pin_ctrl #(
  parameter int unsigned GPIO_WIDTH      = 32,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  reg_wr_en,
  input  logic [2:0]            reg_wr_addr,
  input  logic [31:0]           reg_wr_data,
  input  logic [3:0]            reg_wr_strb,
  input  logic                  reg_rd_en,
  input  logic [2:0]            reg_rd_addr,
  output logic [31:0]           reg_rd_data,
  output logic                  reg_rd_valid,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [GPIO_WIDTH-1:0] gpio_t,
  output logic                  irq
);

  localparam int unsigned W     = GPIO_WIDTH;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

  localparam logic [2:0] ADDR_DATA_OUT   = 3'd0;
  localparam logic [2:0] ADDR_DIR        = 3'd1;
  localparam logic [2:0] ADDR_DATA_IN    = 3'd2;
  localparam logic [2:0] ADDR_IRQ_STATUS = 3'd3;
  localparam logic [2:0] ADDR_IRQ_EN     = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0] data_out_q, data_out_d;
  logic [W-1:0] dir_q, dir_d;
  logic [W-1:0] irq_en_q, irq_en_d;
  logic [W-1:0] irq_status_q, irq_status_d;
  logic [W-1:0] stable_q, stable_d;

  logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;
  logic [W-1:0][CNT_W-1:0]       cnt_q, cnt_d;

  logic        irq_q, irq_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;

  logic [31:0]  wr_mask_full;
  logic [W-1:0] wr_mask;
  logic [W-1:0] wr_bits;
  logic [W-1:0] sync_cur;
  logic [W-1:0] accept;

  // Byte strobes expanded to a per-bit write mask
  always_comb begin
    wr_mask_full = '0;
    for (int b = 0; b < 4; b++) begin
      wr_mask_full[8*b +: 8] = {8{reg_wr_strb[b]}};
    end
  end

  assign wr_mask  = wr_mask_full[W-1:0];
  assign wr_bits  = reg_wr_data[W-1:0] & wr_mask;
  assign sync_cur = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: stage 0 samples the pads
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], gpio_i};
  end

  // Debounce: a bit is accepted once it has differed from stable for DEBOUNCE_CYCLES edges
  always_comb begin
    stable_d = stable_q;
    accept   = '0;
    cnt_d    = '0;
    for (int n = 0; n < W; n++) begin
      if (sync_cur[n] != stable_q[n]) begin
        if (cnt_q[n] == CNT_LAST) begin
          stable_d[n] = sync_cur[n];
          accept[n]   = 1'b1;
        end else begin
          cnt_d[n] = cnt_q[n] + CNT_W'(1);
        end
      end
    end
  end

  // Register file, read capture and interrupt status
  always_comb begin
    data_out_d   = data_out_q;
    dir_d        = dir_q;
    irq_en_d     = irq_en_q;
    irq_status_d = irq_status_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = reg_rd_en;

    if (reg_rd_en) begin
      case (reg_rd_addr)
        ADDR_DATA_OUT:   rd_data_d = 32'(data_out_q);
        ADDR_DIR:        rd_data_d = 32'(dir_q);
        ADDR_DATA_IN:    rd_data_d = 32'(stable_q);
        ADDR_IRQ_STATUS: rd_data_d = 32'(irq_status_q);
        ADDR_IRQ_EN:     rd_data_d = 32'(irq_en_q);
        default:         rd_data_d = '0;
      endcase
    end

    if (reg_wr_en) begin
      case (reg_wr_addr)
        ADDR_DATA_OUT:   data_out_d   = (data_out_q & ~wr_mask) | wr_bits;
        ADDR_DIR:        dir_d        = (dir_q & ~wr_mask) | wr_bits;
        ADDR_IRQ_STATUS: irq_status_d = irq_status_q & ~wr_bits;
        ADDR_IRQ_EN:     irq_en_d     = (irq_en_q & ~wr_mask) | wr_bits;
        default:         ;
      endcase
    end

    // A new accept on an input pin outranks a simultaneous W1C
    irq_status_d = irq_status_d | (accept & ~dir_q);
    irq_d        = |(irq_status_q & irq_en_q);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      data_out_q   <= '0;
      dir_q        <= '0;
      irq_en_q     <= '0;
      irq_status_q <= '0;
      stable_q     <= '0;
      sync_q       <= '0;
      cnt_q        <= '0;
      irq_q        <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      dir_q        <= dir_d;
      irq_en_q     <= irq_en_d;
      irq_status_q <= irq_status_d;
      stable_q     <= stable_d;
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
      irq_q        <= irq_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  assign gpio_o       = data_out_q;
  assign gpio_t       = ~dir_q;
  assign irq          = irq_q;
  assign reg_rd_data  = rd_data_q;
  assign reg_rd_valid = rd_valid_q;

endmodule

// File: tb/tb_gpio_pin_ctrl.sv
// Bench for gpio_pin_ctrl: register-level reference model with per-cycle compare,
// directed literal expectations, then randomized register traffic, pin activity and resets.
module tb_gpio_pin_ctrl;

  localparam int unsigned GW = 32;
  localparam int unsigned SS = 2;
  localparam int unsigned DC = 4;
  localparam int unsigned HL = SS + DC - 1;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic          reg_wr_en = 1'b0;
  logic [2:0]    reg_wr_addr = '0;
  logic [31:0]   reg_wr_data = '0;
  logic [3:0]    reg_wr_strb = '0;
  logic          reg_rd_en = 1'b0;
  logic [2:0]    reg_rd_addr = '0;
  logic [31:0]   reg_rd_data;
  logic          reg_rd_valid;
  logic [GW-1:0] gpio_i = '0;
  logic [GW-1:0] gpio_o;
  logic [GW-1:0] gpio_t;
  logic          irq;

  always #5 ACLK = ~ACLK;

  gpio_pin_ctrl #(.GPIO_WIDTH(GW), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .reg_wr_strb(reg_wr_strb), .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr),
    .reg_rd_data(reg_rd_data), .reg_rd_valid(reg_rd_valid),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_t(gpio_t), .irq(irq)
  );

  typedef struct packed {
    logic [31:0] dout;
    logic [31:0] dir;
    logic [31:0] en;
    logic [31:0] stat;
    logic [31:0] stable;
    logic        irq;
    logic [31:0] rd_data;
    logic        rd_valid;
  } mstate_t;

  mstate_t               m;
  logic [HL-1:0][GW-1:0] hist;   // hist[0] = pad sample taken at the previous edge

  int checks   = 0;
  int failures = 0;

  logic        lit_rd_en = 1'b0;
  logic [31:0] lit_rd = '0;
  logic        lit_irq_en = 1'b0;
  logic        lit_irq = 1'b0;
  logic        lit_gpio_en = 1'b0;
  logic [31:0] lit_o = '0;
  logic [31:0] lit_t = '0;

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = 8'hFF;
    return r;
  endfunction

  // One clock edge of the register map, from the pre-edge state and inputs
  function automatic mstate_t step(input mstate_t s, input logic [HL-1:0][GW-1:0] h);
    mstate_t     n;
    logic [31:0] acc, bm, wb;
    n = s;
    // accept: the last DC synchronised samples all disagree with stable
    acc = '1;
    for (int k = 0; k < int'(DC); k++) acc = acc & (h[SS-1+k] ^ s.stable);
    n.rd_valid = reg_rd_en;
    if (reg_rd_en) begin
      case (reg_rd_addr)
        3'd0: n.rd_data = s.dout;
        3'd1: n.rd_data = s.dir;
        3'd2: n.rd_data = s.stable;
        3'd3: n.rd_data = s.stat;
        3'd4: n.rd_data = s.en;
        default: n.rd_data = '0;
      endcase
    end
    bm = strb_mask(reg_wr_strb);
    wb = reg_wr_data & bm;
    if (reg_wr_en) begin
      case (reg_wr_addr)
        3'd0: n.dout = (s.dout & ~bm) | wb;
        3'd1: n.dir  = (s.dir & ~bm) | wb;
        3'd3: n.stat = s.stat & ~wb;
        3'd4: n.en   = (s.en & ~bm) | wb;
        default: ;
      endcase
    end
    n.stat   = n.stat | (acc & ~s.dir);
    n.stable = s.stable ^ acc;
    n.irq    = |(s.stat & s.en);
    return n;
  endfunction

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      m    <= '0;
      hist <= '0;
    end else begin
      m    <= step(m, hist);
      hist <= {hist[HL-2:0], gpio_i};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare process: DUT against model every cycle, plus literal pins
  always @(posedge ACLK) begin
    #1;
    if (!ARESET) begin
      chk("gpio_o", 32'(gpio_o), m.dout);
      chk("gpio_t", 32'(gpio_t), ~m.dir);
      chk("irq", 32'(irq), 32'(m.irq));
      chk("rd_valid", 32'(reg_rd_valid), 32'(m.rd_valid));
      if (m.rd_valid) chk("rd_data", reg_rd_data, m.rd_data);
      if (lit_rd_en) begin
        chk("lit_rd_valid", 32'(reg_rd_valid), 32'd1);
        chk("lit_rd_data", reg_rd_data, lit_rd);
      end
      if (lit_irq_en) chk("lit_irq", 32'(irq), 32'(lit_irq));
      if (lit_gpio_en) begin
        chk("lit_gpio_o", 32'(gpio_o), lit_o);
        chk("lit_gpio_t", 32'(gpio_t), lit_t);
      end
    end
  end

  task automatic tick();
    @(negedge ACLK);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
    reg_wr_en = 1'b1; reg_wr_addr = a; reg_wr_data = d; reg_wr_strb = s;
    tick();
    reg_wr_en = 1'b0;
  endtask

  task automatic rd_lit(input logic [2:0] a, input logic [31:0] e);
    reg_rd_en = 1'b1; reg_rd_addr = a; lit_rd_en = 1'b1; lit_rd = e;
    tick();
    reg_rd_en = 1'b0; lit_rd_en = 1'b0;
  endtask

  task automatic irq_lit(input logic v);
    lit_irq_en = 1'b1; lit_irq = v;
    tick();
    lit_irq_en = 1'b0;
  endtask

  initial begin
    #200;
    ARESET = 1'b0;
    // reset state
    lit_gpio_en = 1'b1; lit_o = 32'h0; lit_t = 32'hFFFF_FFFF;
    lit_irq_en = 1'b1; lit_irq = 1'b0;
    tick();
    lit_gpio_en = 1'b0; lit_irq_en = 1'b0;
    for (int a = 0; a < 5; a++) rd_lit(3'(a), 32'h0);

    // register RW with strobes
    wr(3'd0, 32'h0000_0001, 4'hF);
    wr(3'd1, 32'h0000_0002, 4'hF);
    wr(3'd4, 32'h0000_0004, 4'hF);
    rd_lit(3'd0, 32'h0000_0001);
    rd_lit(3'd1, 32'h0000_0002);
    rd_lit(3'd4, 32'h0000_0004);
    wr(3'd0, 32'hAABB_CCDD, 4'h2);
    rd_lit(3'd0, 32'h0000_CC01);
    wr(3'd2, 32'hFFFF_FFFF, 4'hF);
    rd_lit(3'd2, 32'h0);

    // glitch reject on bit 3
    wr(3'd1, 32'h0, 4'hF);
    wr(3'd4, 32'h8, 4'hF);
    gpio_i[3] = 1'b1;
    repeat (3) tick();
    gpio_i[3] = 1'b0;
    repeat (10) irq_lit(1'b0);
    rd_lit(3'd2, 32'h0);
    rd_lit(3'd3, 32'h0);

    // debounce accept on bit 0: stable at edge 6, irq at edge 7
    wr(3'd4, 32'h1, 4'hF);
    gpio_i[0] = 1'b1;
    repeat (5) tick();
    lit_irq_en = 1'b1; lit_irq = 1'b0;
    rd_lit(3'd2, 32'h0);
    lit_irq = 1'b1;
    rd_lit(3'd2, 32'h1);
    lit_irq_en = 1'b0;
    rd_lit(3'd3, 32'h1);

    // W1C, irq drops one cycle after the clearing edge
    wr(3'd3, 32'h1, 4'hF);
    irq_lit(1'b0);
    rd_lit(3'd3, 32'h0);

    // W1C landing on the accept edge: set wins
    gpio_i[0] = 1'b0;
    repeat (5) tick();
    wr(3'd3, 32'h1, 4'hF);
    rd_lit(3'd3, 32'h1);
    wr(3'd3, 32'h1, 4'h1);
    tick();

    // output-direction pins drive pads and never raise status
    wr(3'd1, 32'hF, 4'hF);
    wr(3'd0, 32'h5, 4'hF);
    lit_gpio_en = 1'b1; lit_o = 32'h5; lit_t = 32'hFFFF_FFF0;
    tick();
    lit_gpio_en = 1'b0;
    gpio_i[1] = 1'b1;
    repeat (8) tick();
    rd_lit(3'd2, 32'h2);
    rd_lit(3'd3, 32'h0);
    gpio_i[1] = 1'b0;
    repeat (8) tick();

    // randomized traffic, pad activity and asynchronous resets
    for (int c = 0; c < 4000; c++) begin
      reg_wr_en   = ($urandom_range(0, 3) == 0);
      reg_wr_addr = 3'($urandom_range(0, 7));
      reg_wr_data = $urandom;
      reg_wr_strb = 4'($urandom);
      reg_rd_en   = ($urandom_range(0, 1) == 0);
      reg_rd_addr = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) gpio_i = gpio_i ^ ($urandom & $urandom & $urandom);
      if ($urandom_range(0, 499) == 0) begin
        if ($urandom_range(0, 1) == 0) #2; else #7;
        ARESET = 1'b1;
        tick();
        reg_wr_en = 1'b0; reg_rd_en = 1'b0;
        tick();
        ARESET = 1'b0;
      end else begin
        tick();
      end
    end
    reg_wr_en = 1'b0; reg_rd_en = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
